// File: rtl/pill_pkg.sv
// Shared types for the pill-bottling setpoint entry stage and the bottling controller:
// entry FSM encoding, edit positions, BCD digit type and controller state codes.
package pill_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED = 2'd0,
        ST_EDIT   = 2'd1,
        ST_REQ    = 2'd2
    } pte_state_e;

    typedef logic [3:0] bcd_t;

    localparam logic [2:0] POS_P100 = 3'd0;
    localparam logic [2:0] POS_P10  = 3'd1;
    localparam logic [2:0] POS_P1   = 3'd2;
    localparam logic [2:0] POS_B10  = 3'd3;
    localparam logic [2:0] POS_B1   = 3'd4;

    localparam logic [2:0] CTL_SETTING = 3'd0;
    localparam logic [2:0] CTL_FILLING = 3'd1;
    localparam logic [2:0] CTL_DONE    = 3'd2;
    localparam logic [2:0] CTL_FAULT   = 3'd3;

    localparam int REP_FIRST = 500;
    localparam int REP_NEXT  = 250;

    // Digit wraps 9 -> 0 with no carry out; out-of-range codes also recover to 0.
    function automatic bcd_t bcd_inc(input bcd_t d);
        if (d >= 4'd9) begin
            return 4'd0;
        end else begin
            return d + 4'd1;
        end
    endfunction

    function automatic logic [2:0] pos_next(input logic [2:0] p);
        if (p >= POS_B1) begin
            return POS_P100;
        end else begin
            return p + 3'd1;
        end
    endfunction

endpackage

// File: rtl/pill_target_entry_if.sv
// Setpoint handshake between the entry stage (slave side) and the bottling controller (master side).
interface pill_target_entry_if;
    logic        edit_en;
    logic        start_ack;
    logic [11:0] target_pills;
    logic [7:0]  target_bottles;
    logic [2:0]  sel_pos;
    logic [4:0]  flicker_mask;
    logic        start_req;
    logic        cfg_err;

    modport slave (
        input  edit_en, start_ack,
        output target_pills, target_bottles, sel_pos, flicker_mask, start_req, cfg_err
    );

    modport master (
        output edit_en, start_ack,
        input  target_pills, target_bottles, sel_pos, flicker_mask, start_req, cfg_err
    );
endinterface

// File: rtl/pill_target_entry_debounce.sv
// Button debouncer: a level change is accepted after the raw input differs from the
// accepted level for DEBOUNCE_MS consecutive cycles; press pulses on accepted rises.
module btn_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk_1khz,
    input  logic switch_clr,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_MS + 1);

    logic          raw_r;
    logic [CW-1:0] cnt_r;

    // Sample raw input, count stable disagreement, accept level and emit press.
    always_ff @(posedge clk_1khz) begin
        if (switch_clr) begin
            raw_r <= 1'b0;
            cnt_r <= {CW{1'b0}};
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            raw_r <= raw;
            press <= 1'b0;
            if (raw_r != level) begin
                if (cnt_r == CW'(DEBOUNCE_MS - 1)) begin
                    level <= raw_r;
                    press <= raw_r;
                    cnt_r <= {CW{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r <= {CW{1'b0}};
            end
        end
    end
endmodule

// File: rtl/pill_target_entry.sv
// Operator setpoint entry: debounced BCD digit editing, validation and req/ack hand-off.
// Optional inc auto-repeat enabled by defining PTE_AUTOREPEAT_EN.
module pill_target_entry
    import pill_pkg::*;
#(
    parameter int          DEBOUNCE_MS = 20,
    parameter logic [11:0] DEF_PILLS   = 12'h010,
    parameter logic [7:0]  DEF_BOTTLES = 8'h05
) (
    input logic clk_1khz,
    input logic switch_clr,
    input logic btn_sel,
    input logic btn_inc,
    input logic btn_start,
    pill_target_entry_if.slave bus
);
    pte_state_e  state_r, next_state_s;
    logic [11:0] pills_r, pills_n_s;
    logic [7:0]  bottles_r, bottles_n_s;
    logic [2:0]  sel_r, sel_n_s;
    logic        err_r, err_n_s;
    logic [4:0]  mask_r, mask_n_s;
    logic        req_r, req_n_s;

    logic lvl_sel, lvl_inc, lvl_start;
    logic prs_sel, prs_inc, prs_start;
    logic inc_src_s, act_s, cfg_ok_s;
    logic start_evt_s, sel_evt_s, inc_evt_s;
    logic unused_ok_s;

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_sel (
        .clk_1khz(clk_1khz), .switch_clr(switch_clr), .raw(btn_sel), .level(lvl_sel), .press(prs_sel)
    );
    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_inc (
        .clk_1khz(clk_1khz), .switch_clr(switch_clr), .raw(btn_inc), .level(lvl_inc), .press(prs_inc)
    );
    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_start (
        .clk_1khz(clk_1khz), .switch_clr(switch_clr), .raw(btn_start), .level(lvl_start), .press(prs_start)
    );

    assign unused_ok_s = ^{lvl_sel, lvl_start, lvl_inc};

`ifdef PTE_AUTOREPEAT_EN
    logic [9:0] rep_r;
    logic       rep_fire_s;

    assign rep_fire_s = lvl_inc && (rep_r == 10'(REP_FIRST - 1));
    // Hold-time counter for inc; reloads so later repeats come REP_NEXT apart.
    always_ff @(posedge clk_1khz) begin
        if (switch_clr) begin
            rep_r <= 10'd0;
        end else if (!lvl_inc) begin
            rep_r <= 10'd0;
        end else if (rep_fire_s) begin
            rep_r <= 10'(REP_FIRST - REP_NEXT - 1);
        end else begin
            rep_r <= rep_r + 10'd1;
        end
    end
    assign inc_src_s = prs_inc | rep_fire_s;
`else
    assign inc_src_s = prs_inc;
`endif

    assign act_s       = (state_r == ST_EDIT) && bus.edit_en;
    assign cfg_ok_s    = (pills_r != 12'h000) && (bottles_r != 8'h00);
    assign start_evt_s = act_s && prs_start;
    assign sel_evt_s   = act_s && prs_sel && !prs_start;
    assign inc_evt_s   = act_s && inc_src_s && !prs_sel && !prs_start;

    // State and registered handshake/display outputs.
    always_ff @(posedge clk_1khz) begin
        if (switch_clr) begin
            state_r <= ST_LOCKED;
            mask_r  <= 5'b00000;
            req_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            mask_r  <= mask_n_s;
            req_r   <= req_n_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_LOCKED: begin
                if (bus.edit_en) next_state_s = ST_EDIT;
                else             next_state_s = ST_LOCKED;
            end
            ST_EDIT: begin
                if (!bus.edit_en)                 next_state_s = ST_LOCKED;
                else if (start_evt_s && cfg_ok_s) next_state_s = ST_REQ;
                else                              next_state_s = ST_EDIT;
            end
            ST_REQ: begin
                if (bus.start_ack || !bus.edit_en) next_state_s = ST_LOCKED;
                else                               next_state_s = ST_REQ;
            end
            default: next_state_s = ST_LOCKED;
        endcase
    end

    // Output decode from the upcoming state so outputs align with the state register.
    always_comb begin
        mask_n_s = 5'b00000;
        req_n_s  = 1'b0;
        if (next_state_s == ST_EDIT) begin
            mask_n_s = 5'(5'b00001 << sel_n_s);
        end else begin
            mask_n_s = 5'b00000;
        end
        req_n_s = (next_state_s == ST_REQ);
    end

    // Edit datapath: priority start > sel > inc, one digit touched per inc.
    always_comb begin
        pills_n_s   = pills_r;
        bottles_n_s = bottles_r;
        sel_n_s     = sel_r;
        err_n_s     = err_r;
        if ((state_r == ST_LOCKED) && (next_state_s == ST_EDIT)) begin
            sel_n_s = POS_P100;
        end else if (start_evt_s) begin
            err_n_s = !cfg_ok_s;
        end else if (sel_evt_s) begin
            sel_n_s = pos_next(sel_r);
            err_n_s = 1'b0;
        end else if (inc_evt_s) begin
            err_n_s = 1'b0;
            case (sel_r)
                POS_P100: pills_n_s[11:8]  = bcd_inc(pills_r[11:8]);
                POS_P10:  pills_n_s[7:4]   = bcd_inc(pills_r[7:4]);
                POS_P1:   pills_n_s[3:0]   = bcd_inc(pills_r[3:0]);
                POS_B10:  bottles_n_s[7:4] = bcd_inc(bottles_r[7:4]);
                POS_B1:   bottles_n_s[3:0] = bcd_inc(bottles_r[3:0]);
                default:  pills_n_s        = pills_r;
            endcase
        end else begin
            pills_n_s = pills_r;
        end
    end

    // Setpoint, edit position and error flag registers.
    always_ff @(posedge clk_1khz) begin
        if (switch_clr) begin
            pills_r   <= DEF_PILLS;
            bottles_r <= DEF_BOTTLES;
            sel_r     <= POS_P100;
            err_r     <= 1'b0;
        end else begin
            pills_r   <= pills_n_s;
            bottles_r <= bottles_n_s;
            sel_r     <= sel_n_s;
            err_r     <= err_n_s;
        end
    end

    assign bus.target_pills   = pills_r;
    assign bus.target_bottles = bottles_r;
    assign bus.sel_pos        = sel_r;
    assign bus.flicker_mask   = mask_r;
    assign bus.start_req      = req_r;
    assign bus.cfg_err        = err_r;
endmodule

// File: tb/tb_pill_target_entry.sv
// Scoreboard bench for pill_target_entry: a behavioural model pushes expected outputs
// per operation; observed outputs are popped and compared once the operation settles.
module tb_pill_target_entry;
    localparam int DB = 20;

    typedef struct {
        logic [11:0] p;
        logic [7:0]  b;
        logic [2:0]  s;
        logic [4:0]  m;
        logic        r;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic switch_clr, btn_sel, btn_inc, btn_start;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    logic [11:0] m_pills;
    logic [7:0]  m_bottles;
    logic [2:0]  m_sel;
    logic        m_err;
    int          m_state;

    pill_target_entry_if bus();

    pill_target_entry #(.DEBOUNCE_MS(DB), .DEF_PILLS(12'h010), .DEF_BOTTLES(8'h05)) dut (
        .clk_1khz(clk), .switch_clr(switch_clr), .btn_sel(btn_sel),
        .btn_inc(btn_inc), .btn_start(btn_start), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] inc9(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] m_digit(input logic [2:0] p);
        case (p)
            3'd0: return m_pills[11:8];
            3'd1: return m_pills[7:4];
            3'd2: return m_pills[3:0];
            3'd3: return m_bottles[7:4];
            default: return m_bottles[3:0];
        endcase
    endfunction

    task automatic m_reset();
        m_pills = 12'h010; m_bottles = 8'h05; m_sel = 3'd0; m_err = 1'b0; m_state = 0;
    endtask

    task automatic m_event(input logic s, input logic i, input logic st);
        if (m_state == 1) begin
            if (st) begin
                if (m_pills == 12'h000 || m_bottles == 8'h00) m_err = 1'b1;
                else begin m_err = 1'b0; m_state = 2; end
            end else if (s) begin
                m_sel = (m_sel == 3'd4) ? 3'd0 : m_sel + 3'd1;
                m_err = 1'b0;
            end else if (i) begin
                m_err = 1'b0;
                case (m_sel)
                    3'd0: m_pills[11:8]  = inc9(m_pills[11:8]);
                    3'd1: m_pills[7:4]   = inc9(m_pills[7:4]);
                    3'd2: m_pills[3:0]   = inc9(m_pills[3:0]);
                    3'd3: m_bottles[7:4] = inc9(m_bottles[7:4]);
                    default: m_bottles[3:0] = inc9(m_bottles[3:0]);
                endcase
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.p = m_pills; e.b = m_bottles; e.s = m_sel;
        e.m = (m_state == 1) ? 5'(5'b00001 << m_sel) : 5'b00000;
        e.r = (m_state == 2);
        e.e = m_err;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".pills"},   32'(bus.target_pills),   32'(e.p));
            chk({tag, ".bottles"}, 32'(bus.target_bottles), 32'(e.b));
            chk({tag, ".sel"},     32'(bus.sel_pos),        32'(e.s));
            chk({tag, ".mask"},    32'(bus.flicker_mask),   32'(e.m));
            chk({tag, ".req"},     32'(bus.start_req),      32'(e.r));
            chk({tag, ".err"},     32'(bus.cfg_err),        32'(e.e));
        end
    endtask

    task automatic press(input logic s, input logic i, input logic st);
        btn_sel = s; btn_inc = i; btn_start = st;
        cyc(DB + 10);
        btn_sel = 1'b0; btn_inc = 1'b0; btn_start = 1'b0;
        cyc(DB + 10);
        m_event(s, i, st);
    endtask

    task automatic set_digit(input logic [2:0] pos, input logic [3:0] val);
        for (int k = 0; k < 5 && m_sel != pos; k++) press(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10 && m_digit(pos) != val; k++) press(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        switch_clr = 1'b1; btn_sel = 1'b0; btn_inc = 1'b0; btn_start = 1'b0;
        bus.edit_en = 1'b0; bus.start_ack = 1'b0;
        m_reset();
        cyc(3);
        switch_clr = 1'b0;
        cyc(1);
        push_exp(); check_out("reset");

        bus.edit_en = 1'b1;
        cyc(1);
        m_state = 1; m_sel = 3'd0;
        push_exp(); check_out("edit_entry");

        for (int k = 0; k < 5; k++) begin
            press(1'b1, 1'b0, 1'b0);
            push_exp(); check_out("sel_walk");
        end

        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            press(1'b0, 1'b1, 1'b0);
            push_exp(); check_out("inc_ones");
        end
        chk("pills_012", 32'(bus.target_pills), 32'h012);

        for (int k = 0; k < 4; k++) begin
            btn_inc = 1'b1; cyc(5);
            btn_inc = 1'b0; cyc(5);
        end
        btn_inc = 1'b1; cyc(30);
        btn_inc = 1'b0; cyc(30);
        m_event(1'b0, 1'b1, 1'b0);
        push_exp(); check_out("bounce_one_inc");

        press(1'b1, 1'b1, 1'b0);
        push_exp(); check_out("prio_sel_over_inc");

        set_digit(3'd1, 4'd0);
        set_digit(3'd2, 4'd0);
        push_exp(); check_out("pills_zero");
        press(1'b0, 1'b0, 1'b1);
        push_exp(); check_out("cfg_err_set");
        press(1'b0, 1'b1, 1'b0);
        push_exp(); check_out("cfg_err_clear");

        set_digit(3'd0, 4'd1);
        set_digit(3'd1, 4'd2);
        set_digit(3'd2, 4'd0);
        push_exp(); check_out("set_120");
        press(1'b1, 1'b0, 1'b1);
        push_exp(); check_out("start_req");
        cyc(10);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        push_exp(); check_out("req_frozen");
        bus.start_ack = 1'b1; bus.edit_en = 1'b0;
        cyc(1);
        m_state = 0;
        push_exp(); check_out("ack");
        bus.start_ack = 1'b0;

        bus.edit_en = 1'b1;
        cyc(1);
        m_state = 1; m_sel = 3'd0;
        press(1'b0, 1'b0, 1'b1);
        push_exp(); check_out("req_again");
        bus.edit_en = 1'b0;
        cyc(1);
        m_state = 0;
        push_exp(); check_out("withdraw");

        bus.edit_en = 1'b1;
        cyc(1);
        m_state = 1; m_sel = 3'd0;
        press(1'b0, 1'b0, 1'b1);
        push_exp(); check_out("req_pre_clr");
        switch_clr = 1'b1;
        cyc(1);
        m_reset();
        push_exp(); check_out("clr_in_req");
        switch_clr = 1'b0;
        cyc(1);
        m_state = 1;
        push_exp(); check_out("edit_after_clr");

`ifdef PTE_AUTOREPEAT_EN
        btn_inc = 1'b1; cyc(950);
        btn_inc = 1'b0; cyc(30);
        for (int k = 0; k < 3; k++) m_event(1'b0, 1'b1, 1'b0);
        push_exp(); check_out("autorepeat");
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
